axi_lite_arbiter2: RTL
======================

# axi_lite_arbiter2

Two-master to one-slave AXI4-Lite arbiter that shares the single external memory/MMIO port between the instruction fetch unit (master 0) and the load/store unit (master 1). It grants the bus one whole transaction at a time, either an AR→R read or an AW+W→B write. It holds the grant until the response handshake completes, then re-arbitrates. Data, strobes and responses are forwarded unchanged; only valid/ready signals are gated by ownership.

## Interface
Parameters:
- FIXED_PRIO, default 0. 0 = round-robin between masters; 1 = master 1 (LSU) always wins simultaneous requests.

Ports (master vectors packed; master i occupies slice i):
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- m_araddr, m_awaddr, m_wdata  input  2x32 each  per-master read address, write address, write data
- m_wstrb  input  2x4  per-master byte strobes
- m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready  input  2 each  per-master handshake inputs
- m_arready, m_awready, m_wready, m_rvalid, m_bvalid  output  2 each  per-master handshake outputs
- m_rdata  output  2x32  read data (slave rdata broadcast to the owner slot)
- m_rresp, m_bresp  output  2x2 each  responses (owner slot only, else 0)
- s_araddr, s_awaddr, s_wdata  output  32 each  slave address/data
- s_wstrb  output  4  slave strobes
- s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready  output  1 each  slave handshake outputs
- s_arready, s_awready, s_wready, s_rvalid, s_bvalid  input  1 each  slave handshake inputs
- s_rdata  input  32; s_rresp, s_bresp  input  2 each  slave responses
- grant  output  2  one-hot current owner, 00 when idle

## Operation
- States: IDLE, RD, WR. Registered: state, owner (1 bit), last (last granted master), aw_done, w_done, ar_done.
- IDLE: request_i = m_arvalid[i] | m_awvalid[i]. If no request, stay. Otherwise pick a winner:
  - Only one requester: that master.
  - Both, FIXED_PRIO=1: master 1.
  - Both, FIXED_PRIO=0: the master that is not `last`.
  - Then set owner=winner and last=winner.
  - Next state is RD if m_arvalid[winner], else WR. Read wins if a master asserts both.
  - Clear all done flags.
- RD:
  - s_arvalid = m_arvalid[owner] & ~ar_done. s_araddr = m_araddr[owner].
  - m_arready[owner] = s_arready & ~ar_done.
  - Set ar_done on the AR handshake.
  - s_rready = m_rready[owner]. m_rvalid[owner] = s_rvalid.
  - On s_rvalid & s_rready, go to IDLE.
- WR:
  - AW and W are forwarded independently (either order, or the same cycle), each gated by its own done flag, in the same way as AR.
  - s_bready = m_bready[owner]. m_bvalid[owner] = s_bvalid.
  - On the B handshake, go to IDLE. A B handshake before aw_done & w_done is a slave protocol violation and is not checked.
- Non-owner master: every ready/valid output is 0. Its pending requests stay pending, per AXI stability rules.
- In IDLE, all s_* outputs are 0. Address, data and strobe outputs mux from the owner in RD/WR and are 0 otherwise.
- grant = one-hot(owner) in RD/WR, 00 in IDLE.

## Timing
- Reset (synchronous, takes effect at the next clk edge):
  - state=IDLE, last=1 (so master 0 wins the first tie), done flags=0.
  - Every output is 0, including grant.
  - Reset asserted mid-transaction abandons it with no completion to either master. The slave shares rst.
- Arbitration latency: 1 cycle. A request visible in IDLE in cycle N appears on s_*valid in cycle N+1.
- All handshake outputs are combinational from registered state plus the slave/owner inputs. There is no added pipeline stage on data or response paths.
- Minimum gap: after the response handshake in cycle N, the state is IDLE in N+1. The next s_*valid can appear at N+2, so back-to-back transactions have a 1-cycle bubble.
- Done flags prevent re-issuing AR/AW/W after their handshake, even if the owner holds valid high.
- Responses pass through unmodified, including SLVERR/DECERR.

## Test plan
- Single read: m0 araddr=0x3000_0000, arvalid=1 with slave arready in 1 cycle and rdata=0xDEADBEEF on the 2nd cycle -> s_arvalid rises 1 cycle after the request; m_rvalid[0]=1 with m_rdata[0]=0xDEADBEEF; grant=01 then 00; m_rvalid[1]=0 throughout.
- Write with W before AW: m1 awaddr=0x8000_0010, wdata=0x1234_5678, wstrb=0x3; slave accepts W in cycle 1 and AW in cycle 3, B OKAY in cycle 4 -> s_wvalid drops after cycle 1 while s_awvalid stays high until cycle 3; m_bvalid[1] pulses; grant=10.
- Tie, FIXED_PRIO=0: both masters request reads every cycle for 4 transactions -> grant order m0, m1, m0, m1, with 1 idle cycle between transactions.
- Tie, FIXED_PRIO=1: continuous m0 and m1 requests -> m1 wins every arbitration; m0 is served only when m1 deasserts.
- Ownership hold: m1 write pending with slave bvalid delayed 5 cycles while m0 arvalid=1 -> s_arvalid stays 0 until 2 cycles after the m1 B handshake.
- Reset mid-read: rst pulsed 1 cycle after the AR handshake, before R -> the next cycle has all outputs 0, grant=00, state IDLE; a fresh m0 read then completes normally.

Source files
------------

// File: rtl/axi_lite_arbiter2.sv
// Two-master to one-slave AXI4-Lite arbiter. One whole transaction (AR->R or AW+W->B)
// owns the slave port at a time; only valid/ready are gated, payloads pass straight through.
module axi_lite_arbiter2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0][31:0] m_araddr,
  input  logic [1:0][31:0] m_awaddr,
  input  logic [1:0][31:0] m_wdata,
  input  logic [1:0][3:0]  m_wstrb,
  input  logic [1:0]       m_arvalid,
  input  logic [1:0]       m_awvalid,
  input  logic [1:0]       m_wvalid,
  input  logic [1:0]       m_rready,
  input  logic [1:0]       m_bready,
  output logic [1:0]       m_arready,
  output logic [1:0]       m_awready,
  output logic [1:0]       m_wready,
  output logic [1:0]       m_rvalid,
  output logic [1:0]       m_bvalid,
  output logic [1:0][31:0] m_rdata,
  output logic [1:0][1:0]  m_rresp,
  output logic [1:0][1:0]  m_bresp,
  output logic [31:0]      s_araddr,
  output logic [31:0]      s_awaddr,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wstrb,
  output logic             s_arvalid,
  output logic             s_awvalid,
  output logic             s_wvalid,
  output logic             s_rready,
  output logic             s_bready,
  input  logic             s_arready,
  input  logic             s_awready,
  input  logic             s_wready,
  input  logic             s_rvalid,
  input  logic             s_bvalid,
  input  logic [31:0]      s_rdata,
  input  logic [1:0]       s_rresp,
  input  logic [1:0]       s_bresp,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] req;
  logic [1:0] own;
  logic       winner;

  assign req = m_arvalid | m_awvalid;
  assign own = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    winner    = 1'b0;

    m_arready = 2'b00;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_rvalid  = 2'b00;
    m_bvalid  = 2'b00;
    m_rdata   = '0;
    m_rresp   = '0;
    m_bresp   = '0;
    s_araddr  = '0;
    s_awaddr  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    grant     = 2'b00;

    // Payload muxing follows ownership in any busy state.
    if (state_q != StIdle) begin
      grant    = own;
      s_araddr = m_araddr[owner_q];
      s_awaddr = m_awaddr[owner_q];
      s_wdata  = m_wdata[owner_q];
      s_wstrb  = m_wstrb[owner_q];
      m_rdata  = owner_q ? {s_rdata, 32'h0} : {32'h0, s_rdata};
      m_rresp  = owner_q ? {s_rresp, 2'b00} : {2'b00, s_rresp};
      m_bresp  = owner_q ? {s_bresp, 2'b00} : {2'b00, s_bresp};
    end

    case (state_q)
      StIdle: begin
        if (|req) begin
          if (req == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
          end else begin
            winner = req[1];
          end
          owner_d   = winner;
          last_d    = winner;
          state_d   = m_arvalid[winner] ? StRd : StWr;
          ar_done_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StRd: begin
        s_arvalid = m_arvalid[owner_q] & ~ar_done_q;
        m_arready = own & {2{s_arready & ~ar_done_q}};
        s_rready  = m_rready[owner_q];
        m_rvalid  = own & {2{s_rvalid}};
        if (s_arvalid && s_arready) ar_done_d = 1'b1;
        if (s_rvalid && s_rready) state_d = StIdle;
      end
      StWr: begin
        s_awvalid = m_awvalid[owner_q] & ~aw_done_q;
        s_wvalid  = m_wvalid[owner_q] & ~w_done_q;
        m_awready = own & {2{s_awready & ~aw_done_q}};
        m_wready  = own & {2{s_wready & ~w_done_q}};
        s_bready  = m_bready[owner_q];
        m_bvalid  = own & {2{s_bvalid}};
        if (s_awvalid && s_awready) aw_done_d = 1'b1;
        if (s_wvalid && s_wready) w_done_d = 1'b1;
        if (s_bvalid && s_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
